// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and decoder state encoding, used by both the
// sync generator and the sync decoder.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;

  localparam logic [9:0] WD_LIMIT = 10'd1023;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC_H = 2'd1,
    LOCKED = 2'd2
  } vga_state_t;

  // Counter step with wrap back to zero after the last value.
  function automatic logic [9:0] wrap_inc(input logic [9:0] v, input logic [9:0] last);
    return (v == last) ? 10'd0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Normalises a sync input to active-high, keeps its pix_en-gated previous
// value and reports assert/deassert edges for the current pixel tick.
module sync_edge_det #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic sync,
  output logic assert_edge,
  output logic deassert_edge
);

  logic norm;
  logic prev;

  assign norm = POL ? sync : ~sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
    end else if (pix_en) begin
      prev <= norm;
    end
  end

  assign assert_edge   = pix_en & norm & ~prev;
  assign deassert_edge = pix_en & ~norm & prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from incoming hsync/vsync, locks onto clean timing
// and flags horizontal/vertical timing violations.
module vga_sync_decoder import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START_X = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_PRE_X   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] HS_LAST_X  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START_Y = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_PRE_Y   = 10'(V_ACTIVE + V_FP - 1);

  logic hs_rise, hs_fall, vs_rise, vs_fall_unused;

  sync_edge_det #(.POL(SYNC_POL)) u_hs_edge (
    .clk(clk), .rst(rst), .pix_en(pix_en), .sync(hsync),
    .assert_edge(hs_rise), .deassert_edge(hs_fall)
  );

  // vsync deassert timing is not checked, only its assert edge matters.
  sync_edge_det #(.POL(SYNC_POL)) u_vs_edge (
    .clk(clk), .rst(rst), .pix_en(pix_en), .sync(vsync),
    .assert_edge(vs_rise), .deassert_edge(vs_fall_unused)
  );

  vga_state_t state, state_nx;
  logic [9:0] wd, wd_nx, x_nx, y_nx;
  logic       good, good_nx, h_err_nx, v_err_nx;
  logic       active_nx, frame_nx, locked_nx;

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    wd_nx    = wd;
    good_nx  = good;
    h_err_nx = 1'b0;
    v_err_nx = 1'b0;
    if (pix_en) begin
      if (state == HUNT) begin
        x_nx = 10'd0;
        y_nx = 10'd0;
      end else begin
        x_nx = wrap_inc(x, X_LAST);
        if (vs_rise) begin
          y_nx = VS_START_Y;
        end else if (x == X_LAST && !hs_rise) begin
          y_nx = wrap_inc(y, Y_LAST);
        end else begin
          y_nx = y;
        end
      end
      if (hs_rise) begin
        x_nx = HS_START_X;
      end
      wd_nx = hs_rise ? 10'd0 : ((wd == WD_LIMIT) ? wd : wd + 10'd1);

      case (state)
        HUNT: begin
          good_nx = 1'b0;
          if (hs_rise) begin
            state_nx = SYNC_H;
          end
        end
        SYNC_H: begin
          if (hs_rise) begin
            if (x != HS_PRE_X) begin
              h_err_nx = 1'b1;
              good_nx  = 1'b0;
            end else begin
              good_nx  = 1'b1;
            end
          end
          if (vs_rise && good_nx) begin
            state_nx = LOCKED;
          end
          if (wd_nx == WD_LIMIT) begin
            state_nx = HUNT;
          end
        end
        LOCKED: begin
          if (vs_rise && y != VS_PRE_Y) begin
            v_err_nx = 1'b1;
            state_nx = SYNC_H;
          end
          if (wd_nx == WD_LIMIT) begin
            state_nx = HUNT;
          end
          // A horizontal violation overrides any vsync-driven transition.
          if ((hs_rise && x != HS_PRE_X) || (hs_fall && x != HS_LAST_X)) begin
            h_err_nx = 1'b1;
            state_nx = HUNT;
          end
        end
        default: begin
          state_nx = HUNT;
        end
      endcase
    end

    locked_nx = (state_nx == LOCKED);
    active_nx = locked_nx && (x_nx < X_ACT) && (y_nx < Y_ACT);
    frame_nx  = pix_en && locked_nx && (x_nx == 10'd0) && (y_nx == 10'd0) &&
                ((x != 10'd0) || (y != 10'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      x           <= 10'd0;
      y           <= 10'd0;
      wd          <= 10'd0;
      good        <= 1'b0;
      active      <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      state       <= state_nx;
      x           <= x_nx;
      y           <= y_nx;
      wd          <= wd_nx;
      good        <= good_nx;
      active      <= active_nx;
      locked      <= locked_nx;
      frame_start <= frame_nx;
      h_err       <= h_err_nx;
      v_err       <= v_err_nx;
    end
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (horizontal pixel counts); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (vertical line counts); SYNC_POL 0 (0 = active-low syncs).
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pix_en  in  1  pixel tick; all decoding advances only on cycles with pix_en=1.
REQ-005 hsync  in  1  horizontal sync under decode.
REQ-006 vsync  in  1  vertical sync under decode.
REQ-007 x  out  10  recovered column of the last sampled pixel, 0..799.
REQ-008 y  out  10  recovered row, 0..524.
REQ-009 active  out  1  locked and x<H_ACTIVE and y<V_ACTIVE.
REQ-010 locked  out  1  high in state LOCKED only.
REQ-011 frame_start  out  1  one-clk pulse when locked and (x,y) becomes (0,0).
REQ-012 h_err  out  1  one-clk pulse on horizontal timing violation.
REQ-013 v_err  out  1  one-clk pulse on vertical timing violation.

Function
REQ-014 On each pix_en cycle, hsync/vsync SHALL be normalised by SYNC_POL and registered; an edge SHALL be the current normalised input compared with its registered value.
REQ-015 All outputs SHALL be registered; x/y SHALL reflect a pix_en sample on the clk edge on which that sample is taken.
REQ-016 H_TOTAL=800 and V_TOTAL=525 SHALL be derived from the parameters; HS_START=656, HS_END=752, VS_START=490.
REQ-017 Free-run: on pix_en without sync edge, x SHALL go to 0 after 799, otherwise x+1; y SHALL advance only when x wraps, going to 0 after 524.
REQ-018 hsync assert edge SHALL load x=HS_START regardless of state; vsync assert edge SHALL load y=VS_START in states SYNC_H and LOCKED.
REQ-019 FSM states SHALL be HUNT, SYNC_H, LOCKED.
REQ-020 HUNT: x,y SHALL hold 0; the first hsync assert edge SHALL move to SYNC_H.
REQ-021 SYNC_H: hsync assert edge with previous x != HS_START-1 SHALL pulse h_err and clear the good-line flag, else set it; vsync assert edge with good-line flag set SHALL move to LOCKED.
REQ-022 LOCKED: hsync assert edge with previous x != HS_START-1, or hsync deassert edge with previous x != HS_END-1, SHALL pulse h_err and go to HUNT.
REQ-023 LOCKED: vsync assert edge with previous y != VS_START-1 SHALL pulse v_err and go to SYNC_H; y SHALL still load VS_START.
REQ-024 Watchdog: 10-bit counter of pix_en ticks since the last hsync assert edge; reaching 1023 in SYNC_H or LOCKED SHALL go to HUNT without an error pulse.
REQ-025 Simultaneous hsync and vsync assert edges SHALL both be processed in that cycle; an h_err transition to HUNT SHALL take priority over vsync-driven transitions.
REQ-026 With pix_en=0, state, x, y and sync registers SHALL hold, and pulse outputs SHALL be 0.

Reset
REQ-027 rst SHALL force: state HUNT, x=0, y=0, sync registers to the deasserted level, watchdog 0, good-line flag 0, and all outputs 0.
REQ-028 rst mid-frame SHALL take priority over pix_en and every edge; decoding SHALL restart from HUNT on the next cycle.

Structure
REQ-029 The timing constants (H_*/V_* defaults, derived totals, HS_START/HS_END/VS_START) and the FSM state encoding SHALL live in shared package vga_timing_pkg, also used by the generator side.
REQ-030 One sub-module SHALL be used: sync_edge_det (polarity normalise, pix_en-gated register, assert/deassert edge pulses), instantiated once for hsync and once for vsync.

Verification
REQ-031 Feed clean 640x480 generator for 2 frames, pix_en every cycle -> locked at first vsync edge after at least one good line; x=0,y=0 with one frame_start per frame; active high for exactly 307200 ticks per frame.
REQ-032 Once locked, shift one hsync by +1 pixel -> h_err single pulse, locked=0 next clk, x=656 at that edge; relock at the next vsync edge.
REQ-033 Once locked, hsync pulse width 95 instead of 96 -> h_err at the deassert edge, state HUNT.
REQ-034 Once locked, vsync assert at line 491 -> v_err pulse, y=490, state SYNC_H, locked=0.
REQ-035 Stop hsync for 1100 ticks while locked -> HUNT after 1023 ticks, no h_err/v_err pulse.
REQ-036 pix_en every 4th clk and rst asserted mid-line at x=300 -> all outputs 0 next clk; relock on the following frame.
